pmem_arbiter: RTL and testbench

- Arbitrates the single physical-memory port between the instruction cache (IF-stage fetch misses) and the data cache (MEM-stage loads, stores and writebacks driven by the EX/MEM control bits).
- Registers each granted request onto the pmem bus and holds it until pmem_resp.
- Routes the response back to the granted cache only.
- Sits between the two L1 caches and physical memory in the pipelined LC-3b datapath.

---
 rtl/pmem_arbiter_if.sv | 36 +++
 rtl/pmem_arbiter.sv | 85 ++++++++
 tb/tb_pmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_if.sv
// Bus bundle between the two L1 caches, the physical-memory arbiter and physical memory.
// The slave modport is the arbiter's view; the master modport is the caches/memory side.
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  // I-cache side
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  // D-cache side
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  // Physical memory side
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Physical-memory port arbiter between the I-cache and D-cache of the pipelined LC-3b.
// A granted request is registered onto the pmem bus and held until pmem_resp; the
// response is routed only to the granted cache, followed by one dead RELEASE cycle.
// Optional feature macro PMEM_ARB_ROUND_ROBIN_EN: when both caches contend in IDLE,
// grant the side opposite to the last grant. Without it, D (older MEM stage) wins.
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  pmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t state;
  grant_t last_grant;
  grant_t next_grant;
  logic   want_d;
  logic   want_i;
  logic   pick_d;

  // Grant decision for the IDLE state and the resulting last_grant value.
  always_comb begin
    want_d = bus.d_read | bus.d_write;
    want_i = bus.i_read;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    pick_d = want_d & (~want_i | (last_grant == GRANT_I));
`else
    pick_d = want_d;
`endif
    next_grant = last_grant;
    if (pick_d) next_grant = GRANT_D;
    else if (want_i) next_grant = GRANT_I;
  end

  // Arbitration FSM with registered pmem strobes, address and write line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_grant       <= GRANT_I;
      bus.pmem_read    <= 1'b0;
      bus.pmem_write   <= 1'b0;
      bus.pmem_address <= {ADDR_WIDTH{1'b0}};
      bus.pmem_wdata   <= {LINE_WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          last_grant <= next_grant;
          if (pick_d) begin
            // A simultaneous read and write is issued as a write.
            state            <= SERVE_D;
            bus.pmem_address <= bus.d_address;
            bus.pmem_wdata   <= bus.d_wdata;
            bus.pmem_write   <= bus.d_write;
            bus.pmem_read    <= ~bus.d_write;
          end else if (want_i) begin
            state            <= SERVE_I;
            bus.pmem_address <= bus.i_address;
            bus.pmem_read    <= 1'b1;
            bus.pmem_write   <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.pmem_resp) begin
            state          <= RELEASE;
            bus.pmem_read  <= 1'b0;
            bus.pmem_write <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is steered only to the cache currently being served.
  assign bus.i_resp  = bus.pmem_resp & (state == SERVE_I);
  assign bus.d_resp  = bus.pmem_resp & (state == SERVE_D);
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: expected pmem transactions are queued when a
// cache request is driven and popped when the arbiter puts a transaction on the bus.
module tb_pmem_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_d;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } exp_t;

  typedef struct packed {
    logic          timeout;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic          iresp;
    logic          dresp;
    logic          rdata_ok;
    logic          stable;
    logic [1:0]    after;
  } obs_t;

  exp_t sb[$];
  logic model_lg_d;  // bench model of last_grant (1 = D)

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Records an expected grant and advances the last_grant model.
  task automatic push_exp(input logic is_d, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] w);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = wr ? w : '0;
    sb.push_back(e);
    model_lg_d = is_d;
  endtask

  // Acts as memory plus requesting caches for one transaction; captures observations only.
  task automatic run_txn(input int lat, output obs_t o);
    logic [AW-1:0] ia, da;
    logic [LW-1:0] dw, rd;
    int n;
    o = '0;
    o.stable = 1'b1;
    n = 0;
    while (!(bus.pmem_read | bus.pmem_write) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!(bus.pmem_read | bus.pmem_write)) begin
      o.timeout = 1'b1;
      return;
    end
    o.rd = bus.pmem_read; o.wr = bus.pmem_write; o.addr = bus.pmem_address;
    o.wdata = bus.pmem_write ? bus.pmem_wdata : '0;
    ia = bus.i_address; da = bus.d_address; dw = bus.d_wdata;
    for (int k = 0; k < lat; k++) begin
      bus.i_address = AW'($urandom); bus.d_address = AW'($urandom);
      bus.d_wdata = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      if ({bus.pmem_read, bus.pmem_write, bus.pmem_address} !== {o.rd, o.wr, o.addr}) o.stable = 1'b0;
      if (o.wr && bus.pmem_wdata !== o.wdata) o.stable = 1'b0;
    end
    bus.i_address = ia; bus.d_address = da; bus.d_wdata = dw;
    rd = {$urandom, $urandom, $urandom, $urandom};
    bus.pmem_rdata = rd;
    bus.pmem_resp = 1'b1;
    #1;
    o.iresp = bus.i_resp; o.dresp = bus.d_resp;
    o.rdata_ok = (bus.i_rdata === rd) && (bus.d_rdata === rd);
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    if (o.iresp) bus.i_read = 1'b0;
    if (o.dresp) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    o.after = {bus.pmem_read, bus.pmem_write};
  endtask

  task automatic test_reset;
    obs_t o; exp_t e;
    rst_n = 1'b0;
    bus.i_read = 1'b1; bus.i_address = 16'h1230;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    model_lg_d = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.pmem_wdata, bus.i_resp, bus.d_resp} !== '0) begin
      bad++; $display("FAIL reset_state got rd=%b wr=%b addr=%h resp=%b%b expected all zero",
                      bus.pmem_read, bus.pmem_write, bus.pmem_address, bus.i_resp, bus.d_resp);
    end
    rst_n = 1'b1;
    push_exp(1'b0, 1'b0, 16'h1230, '0);
    @(posedge clk); #1;
    total++;
    if ({bus.pmem_read, bus.pmem_address} !== {1'b1, 16'h1230}) begin
      bad++; $display("FAIL reset_grant got rd=%b addr=%h expected rd=1 addr=1230", bus.pmem_read, bus.pmem_address);
    end
    run_txn(3, o);
    e = sb.pop_front();
    total++;
    if (o !== {1'b0, ~e.wr, e.wr, e.addr, e.wdata, ~e.is_d, e.is_d, 1'b1, 1'b1, 2'b00}) begin
      bad++; $display("FAIL reset_txn got to=%b rd=%b wr=%b addr=%h ir=%b dr=%b rdok=%b st=%b af=%b expected addr=%h d=%b",
                      o.timeout, o.rd, o.wr, o.addr, o.iresp, o.dresp, o.rdata_ok, o.stable, o.after, e.addr, e.is_d);
    end
  endtask

  task automatic test_d_write;
    obs_t o; exp_t e;
    bus.d_write = 1'b1; bus.d_address = 16'h4A50;
    bus.d_wdata = 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D;
    push_exp(1'b1, 1'b1, 16'h4A50, bus.d_wdata);
    run_txn(4, o);
    e = sb.pop_front();
    total++;
    if (o !== {1'b0, ~e.wr, e.wr, e.addr, e.wdata, ~e.is_d, e.is_d, 1'b1, 1'b1, 2'b00}) begin
      bad++; $display("FAIL d_write got to=%b rd=%b wr=%b addr=%h wd=%h ir=%b dr=%b rdok=%b st=%b af=%b expected addr=%h wd=%h",
                      o.timeout, o.rd, o.wr, o.addr, o.wdata, o.iresp, o.dresp, o.rdata_ok, o.stable, o.after, e.addr, e.wdata);
    end
  endtask

  task automatic test_contest;
    obs_t o; exp_t e; logic first_d;
    bus.d_read = 1'b1; bus.d_address = 16'h4A50;
    bus.i_read = 1'b1; bus.i_address = 16'h1230;
    first_d = RR ? ~model_lg_d : 1'b1;
    push_exp(first_d, 1'b0, first_d ? 16'h4A50 : 16'h1230, '0);
    push_exp(~first_d, 1'b0, first_d ? 16'h1230 : 16'h4A50, '0);
    for (int t = 0; t < 2; t++) begin
      run_txn(1 + t, o);
      e = sb.pop_front();
      total++;
      if (o !== {1'b0, ~e.wr, e.wr, e.addr, e.wdata, ~e.is_d, e.is_d, 1'b1, 1'b1, 2'b00}) begin
        bad++; $display("FAIL contest_%0d got to=%b rd=%b addr=%h ir=%b dr=%b rdok=%b st=%b af=%b expected addr=%h d=%b",
                        t, o.timeout, o.rd, o.addr, o.iresp, o.dresp, o.rdata_ok, o.stable, o.after, e.addr, e.is_d);
      end
    end
  endtask

  task automatic test_back_to_back;
    obs_t o; exp_t e; logic pick;
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_lg_d = 1'b0;
    for (int t = 0; t < 4; t++) begin
      bus.d_read = 1'b1; bus.d_address = 16'h4A50;
      bus.i_read = 1'b1; bus.i_address = 16'h1230;
      pick = RR ? ~model_lg_d : 1'b1;
      push_exp(pick, 1'b0, pick ? 16'h4A50 : 16'h1230, '0);
      run_txn(1, o);
      e = sb.pop_front();
      total++;
      if (o !== {1'b0, ~e.wr, e.wr, e.addr, e.wdata, ~e.is_d, e.is_d, 1'b1, 1'b1, 2'b00}) begin
        bad++; $display("FAIL b2b_%0d got to=%b addr=%h ir=%b dr=%b rdok=%b st=%b af=%b expected addr=%h d=%b",
                        t, o.timeout, o.addr, o.iresp, o.dresp, o.rdata_ok, o.stable, o.after, e.addr, e.is_d);
      end
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort;
    obs_t o; exp_t e; int n;
    bus.d_write = 1'b1; bus.d_address = 16'h7770; bus.d_wdata = {4{32'hA5A5_5A5A}};
    n = 0;
    while (!bus.pmem_write && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    total++;
    if (bus.pmem_write !== 1'b1) begin
      bad++; $display("FAIL abort_setup got wr=%b expected wr=1", bus.pmem_write);
    end
    rst_n = 1'b0;
    bus.pmem_resp = 1'b1;
    #1;
    total++;
    if ({bus.pmem_write, bus.pmem_read, bus.d_resp, bus.i_resp} !== 4'b0000) begin
      bad++; $display("FAIL abort_drop got wr=%b rd=%b dr=%b ir=%b expected all 0",
                      bus.pmem_write, bus.pmem_read, bus.d_resp, bus.i_resp);
    end
    bus.pmem_resp = 1'b0; bus.d_write = 1'b0;
    bus.i_read = 1'b1; bus.i_address = 16'h1230;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_lg_d = 1'b0;
    push_exp(1'b0, 1'b0, 16'h1230, '0);
    @(posedge clk); #1;
    total++;
    if ({bus.pmem_read, bus.pmem_write, bus.pmem_address} !== {2'b10, 16'h1230}) begin
      bad++; $display("FAIL abort_regrant got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=1230",
                      bus.pmem_read, bus.pmem_write, bus.pmem_address);
    end
    run_txn(2, o);
    e = sb.pop_front();
    total++;
    if (o !== {1'b0, ~e.wr, e.wr, e.addr, e.wdata, ~e.is_d, e.is_d, 1'b1, 1'b1, 2'b00}) begin
      bad++; $display("FAIL abort_txn got to=%b addr=%h ir=%b dr=%b rdok=%b st=%b af=%b expected addr=%h",
                      o.timeout, o.addr, o.iresp, o.dresp, o.rdata_ok, o.stable, o.after, e.addr);
    end
  endtask

  task automatic test_stray_resp;
    obs_t o; exp_t e; logic [1:0] resps;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.pmem_resp = 1'b1;
    #1;
    resps = {bus.i_resp, bus.d_resp};
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    total++;
    if ({resps, bus.pmem_read, bus.pmem_write} !== 4'b0000) begin
      bad++; $display("FAIL stray_resp got resps=%b rd=%b wr=%b expected 0", resps, bus.pmem_read, bus.pmem_write);
    end
    // A stray resp that moved the FSM out of IDLE would delay this grant by a cycle.
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 16'h4A50;
    bus.d_wdata = {$urandom, $urandom, $urandom, $urandom};
    push_exp(1'b1, 1'b1, 16'h4A50, bus.d_wdata);
    @(posedge clk); #1;
    total++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b01) begin
      bad++; $display("FAIL dual_grant got rd=%b wr=%b expected rd=0 wr=1", bus.pmem_read, bus.pmem_write);
    end
    run_txn(2, o);
    e = sb.pop_front();
    total++;
    if (o !== {1'b0, ~e.wr, e.wr, e.addr, e.wdata, ~e.is_d, e.is_d, 1'b1, 1'b1, 2'b00}) begin
      bad++; $display("FAIL dual_txn got to=%b rd=%b wr=%b addr=%h wd=%h dr=%b rdok=%b st=%b af=%b expected wd=%h",
                      o.timeout, o.rd, o.wr, o.addr, o.wdata, o.dresp, o.rdata_ok, o.stable, o.after, e.wdata);
    end
  endtask

  initial begin
    test_reset();
    test_d_write();
    test_contest();
    test_back_to_back();
    test_reset_abort();
    test_stray_resp();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_empty got %0d left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
